// File: rtl/axi_aw_packetizer_pkg.sv
// Shared NoC packet types: packet-type enum, header field layout, default header struct
// and a width-generic header builder reused by the read packetizer and egress depacketizer.
package axi_aw_packetizer_pkg;

  typedef enum logic [1:0] {
    PKT_WRITE = 2'b01,
    PKT_READ  = 2'b10,
    PKT_RESP  = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } aw_state_e;

  localparam int unsigned HDR_TYPE_W  = 2;
  localparam int unsigned HDR_LEN_W   = 8;
  localparam int unsigned HDR_SIZE_W  = 3;
  localparam int unsigned HDR_BURST_W = 2;
  localparam int unsigned HDR_FIXED_W = HDR_TYPE_W + HDR_LEN_W + HDR_SIZE_W + HDR_BURST_W;
  localparam int unsigned HDR_MAX_W   = 64;

  localparam int unsigned NOC_DEF_XW     = 2;
  localparam int unsigned NOC_DEF_YW     = 2;
  localparam int unsigned NOC_DEF_IDW    = 4;
  localparam int unsigned NOC_DEF_FLIT_W = 32;
  localparam int unsigned NOC_DEF_HDR_W  = HDR_FIXED_W + 2*NOC_DEF_XW + 2*NOC_DEF_YW + NOC_DEF_IDW;

  // Header as seen in a default 4x4 mesh with 4-bit IDs and 32-bit flits (MSB first).
  typedef struct packed {
    logic [NOC_DEF_FLIT_W-NOC_DEF_HDR_W-1:0] pad;
    logic [HDR_BURST_W-1:0]                  burst;
    logic [HDR_SIZE_W-1:0]                   size;
    logic [HDR_LEN_W-1:0]                    len;
    logic [NOC_DEF_IDW-1:0]                  id;
    logic [NOC_DEF_YW-1:0]                   src_y;
    logic [NOC_DEF_XW-1:0]                   src_x;
    logic [NOC_DEF_YW-1:0]                   dst_y;
    logic [NOC_DEF_XW-1:0]                   dst_x;
    pkt_type_e                               pkt_type;
  } noc_hdr_t;

  function automatic logic [HDR_MAX_W-1:0] fit_field(input logic [15:0] v, input int unsigned w);
    return HDR_MAX_W'(v) & ((64'd1 << w) - 64'd1);
  endfunction

  // Packs fields LSB first; widths are elaboration constants at every call site.
  function automatic logic [HDR_MAX_W-1:0] build_header(
    input pkt_type_e   ptype,
    input int unsigned xw,
    input int unsigned yw,
    input int unsigned idw,
    input logic [15:0] dst_x,
    input logic [15:0] dst_y,
    input logic [15:0] src_x,
    input logic [15:0] src_y,
    input logic [15:0] id,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [HDR_MAX_W-1:0] h;
    int unsigned          pos;
    h   = HDR_MAX_W'(ptype);
    pos = HDR_TYPE_W;
    h   = h | (fit_field(dst_x, xw) << pos);  pos = pos + xw;
    h   = h | (fit_field(dst_y, yw) << pos);  pos = pos + yw;
    h   = h | (fit_field(src_x, xw) << pos);  pos = pos + xw;
    h   = h | (fit_field(src_y, yw) << pos);  pos = pos + yw;
    h   = h | (fit_field(id, idw) << pos);    pos = pos + idw;
    h   = h | (HDR_MAX_W'(len) << pos);       pos = pos + HDR_LEN_W;
    h   = h | (HDR_MAX_W'(size) << pos);      pos = pos + HDR_SIZE_W;
    h   = h | (HDR_MAX_W'(burst) << pos);
    return h;
  endfunction

endpackage

// File: rtl/axi_aw_packetizer.sv
// AXI4 write-burst to NoC stream packetizer: header flit, address flit, then len+1 data flits.
// Optional performance counters are built when NI_PMU_EN is defined.
module axi_aw_packetizer
  import axi_aw_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_strb,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             pmu_pkt_cnt,
  output logic [31:0]             pmu_stall_cnt
);

  localparam int unsigned XW     = $clog2(MAX_ROUTERS_X);
  localparam int unsigned YW     = $clog2(MAX_ROUTERS_Y);
  localparam int          STRB_W = DATA_WIDTH / 8;

  if (2 + 2*XW + 2*YW + ID_WIDTH + 13 > DATA_WIDTH) begin : g_hdr_chk
    $error("axi_aw_packetizer: header fields do not fit in DATA_WIDTH");
  end
  if (ADDR_WIDTH > DATA_WIDTH) begin : g_addr_chk
    $error("axi_aw_packetizer: ADDR_WIDTH exceeds DATA_WIDTH");
  end

  aw_state_e               state_q, state_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   flit_q, flit_d;
  logic                    flit_vld_q, flit_vld_d;
  logic                    awready_q, awready_d;
  logic                    aw_hs_s;
  logic                    in_data_s;
  logic [HDR_MAX_W-1:0]    hdr_s;
  logic                    unused_wlast_s;

  // Framing comes from the beat counter alone, so wlast is deliberately not consumed.
  assign unused_wlast_s = wlast;

  assign aw_hs_s = awvalid & awready_q;
  assign hdr_s   = build_header(PKT_WRITE, XW, YW, ID_WIDTH,
                                16'(awaddr[ADDR_WIDTH-1 -: XW]),
                                16'(awaddr[ADDR_WIDTH-1-XW -: YW]),
                                16'(ROUTER_X), 16'(ROUTER_Y), 16'(awid),
                                awlen, awsize, awburst);

  // Next-state and registered-output logic for the packet FSM.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    flit_d     = flit_q;
    flit_vld_d = flit_vld_q;
    awready_d  = awready_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs_s) begin
          addr_d     = awaddr;
          beat_cnt_d = awlen;
          flit_d     = DATA_WIDTH'(hdr_s);
          flit_vld_d = 1'b1;
          awready_d  = 1'b0;
          state_d    = ST_HDR;
        end else begin
          awready_d  = 1'b1;
        end
      end
      ST_HDR: begin
        if (out_ready) begin
          flit_d  = DATA_WIDTH'(addr_q);
          state_d = ST_ADDR;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_ADDR: begin
        if (out_ready) begin
          flit_d     = '0;
          flit_vld_d = 1'b0;
          state_d    = ST_DATA;
        end else begin
          state_d    = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (wvalid && out_ready && (beat_cnt_q == 8'd0)) begin
          awready_d  = 1'b1;
          state_d    = ST_IDLE;
        end else if (wvalid && out_ready) begin
          beat_cnt_d = beat_cnt_q - 8'd1;
        end else begin
          state_d    = ST_DATA;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        flit_d     = '0;
        flit_vld_d = 1'b0;
        awready_d  = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 8'd0;
      addr_q     <= '0;
      flit_q     <= '0;
      flit_vld_q <= 1'b0;
      awready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      flit_q     <= flit_d;
      flit_vld_q <= flit_vld_d;
      awready_q  <= awready_d;
    end
  end

  // Data beats pass straight through so the W channel's own stability rules carry over.
  assign in_data_s = (state_q == ST_DATA);
  assign awready   = awready_q;
  assign wready    = in_data_s & out_ready;
  assign out_valid = in_data_s ? wvalid : flit_vld_q;
  assign out_data  = in_data_s ? wdata  : flit_q;
  assign out_strb  = in_data_s ? wstrb  : {STRB_W{flit_vld_q}};
  assign out_last  = in_data_s & (beat_cnt_q == 8'd0);

`ifdef NI_PMU_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating packet and back-pressure counters.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid && out_ready && out_last && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pmu_pkt_cnt   = pkt_cnt_q;
  assign pmu_stall_cnt = stall_cnt_q;
`else
  assign pmu_pkt_cnt   = 32'd0;
  assign pmu_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_axi_aw_packetizer.sv
// Directed, table-driven bench for axi_aw_packetizer (default build and NI_PMU_EN build).
module tb_axi_aw_packetizer;
  import axi_aw_packetizer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last, out_valid, out_ready;
  logic [31:0] pmu_pkt_cnt, pmu_stall_cnt;

  logic        b_awready, b_wready, b_out_last, b_out_valid;
  logic [31:0] b_out_data, b_pmu_pkt_cnt, b_pmu_stall_cnt;
  logic [3:0]  b_out_strb;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_beat;
    int          stall;
    logic [31:0] exp_hdr;
    logic [31:0] exp_hdr_b;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  axi_aw_packetizer dut (
    .clk(clk), .rst_n(rst_n), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .pmu_pkt_cnt(pmu_pkt_cnt), .pmu_stall_cnt(pmu_stall_cnt)
  );

  axi_aw_packetizer #(.ROUTER_X(2), .ROUTER_Y(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(b_awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(b_wready),
    .out_data(b_out_data), .out_strb(b_out_strb), .out_last(b_out_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .pmu_pkt_cnt(b_pmu_pkt_cnt), .pmu_stall_cnt(b_pmu_stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input vec_t v);
    int waited;
    noc_hdr_t hb;
    waited    = 0;
    awaddr    = v.addr;
    awid      = v.id;
    awlen     = v.len;
    awsize    = v.size;
    awburst   = v.burst;
    awvalid   = 1'b1;
    wvalid    = 1'b1;
    wdata     = 32'hDEAD_BEEF;
    wstrb     = 4'hF;
    wlast     = 1'b0;
    out_ready = 1'b1;
    while (!awready && waited < 20) begin
      step();
      waited++;
    end
    chk("aw_accept", {63'd0, awready}, 64'd1);
    if (!awready) begin
      awvalid = 1'b0;
      return;
    end
    step();
    awvalid = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      out_ready = 1'b0;
      #1;
      chk("hdr_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hdr_hold_data", {32'd0, out_data}, {32'd0, v.exp_hdr});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("hdr_valid", {63'd0, out_valid}, 64'd1);
    chk("hdr_data", {32'd0, out_data}, {32'd0, v.exp_hdr});
    chk("hdr_strb", {60'd0, out_strb}, 64'hF);
    chk("hdr_last", {63'd0, out_last}, 64'd0);
    chk("hdr_wready", {63'd0, wready}, 64'd0);
    chk("hdr_awready", {63'd0, awready}, 64'd0);
    chk("b_hdr_data", {32'd0, b_out_data}, {32'd0, v.exp_hdr_b});
    chk("b_hdr_valid", {63'd0, b_out_valid}, 64'd1);
    chk("b_hdr_strb", {60'd0, b_out_strb}, 64'hF);
    hb = noc_hdr_t'(b_out_data);
    chk("b_hdr_src_x", {62'd0, hb.src_x}, 64'd2);
    chk("b_hdr_src_y", {62'd0, hb.src_y}, 64'd1);
    step();
    #1;
    chk("addr_valid", {63'd0, out_valid}, 64'd1);
    chk("addr_data", {32'd0, out_data}, {32'd0, v.addr});
    chk("addr_last", {63'd0, out_last}, 64'd0);
    chk("addr_wready", {63'd0, wready}, 64'd0);
    step();
    for (int b = 0; b <= int'(v.len); b++) begin
      wdata = 32'hD000_0000 | 32'(b);
      wstrb = 4'(b + 1);
      wlast = (b == v.wlast_beat);
      #1;
      chk("data_valid", {63'd0, out_valid}, 64'd1);
      chk("data_data", {32'd0, out_data}, {32'd0, 32'hD000_0000 | 32'(b)});
      chk("data_strb", {60'd0, out_strb}, {60'd0, 4'(b + 1)});
      chk("data_last", {63'd0, out_last}, {63'd0, (b == int'(v.len))});
      chk("data_wready", {63'd0, wready}, 64'd1);
      chk("b_data_wready", {63'd0, b_wready}, 64'd1);
      chk("b_data_last", {63'd0, b_out_last}, {63'd0, (b == int'(v.len))});
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    #1;
    chk("idle_awready", {63'd0, awready}, 64'd1);
    chk("b_idle_awready", {63'd0, b_awready}, 64'd1);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_wready", {63'd0, wready}, 64'd0);
  endtask

  initial begin
    //          addr          id     len    size   burst  wlast stall exp_hdr        exp_hdr_b
    vecs[0] = '{32'h4000_0010, 4'h3, 8'd3, 3'd2, 2'd1, 3,    0,    32'h0280_CC05, 32'h0280_CD85};
    vecs[1] = '{32'h8000_0020, 4'h5, 8'd0, 3'd2, 2'd1, 0,    0,    32'h0280_1409, 32'h0280_1589};
    vecs[2] = '{32'h4000_0010, 4'h3, 8'd3, 3'd2, 2'd1, 3,    5,    32'h0280_CC05, 32'h0280_CD85};
    vecs[3] = '{32'h1000_0100, 4'hA, 8'd3, 3'd2, 2'd1, 1,    0,    32'h0280_E811, 32'h0280_E991};
    vecs[4] = '{32'hF000_0000, 4'hF, 8'd1, 3'd1, 2'd2, 1,    0,    32'h0440_7C3D, 32'h0440_7DBD};
    vecs[5] = '{32'hC000_0000, 4'h1, 8'd1, 3'd2, 2'd1, 1,    0,    32'h0280_440D, 32'h0280_458D};
    vecs[6] = '{32'hC000_0000, 4'h2, 8'd0, 3'd2, 2'd1, 0,    0,    32'h0280_080D, 32'h0280_098D};

    rst_n = 1'b0; awid = 4'h0; awaddr = 32'h0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
    awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_wready", {63'd0, wready}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_pkt_cnt", {32'd0, pmu_pkt_cnt}, 64'd0);
    chk("rst_stall_cnt", {32'd0, pmu_stall_cnt}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_awready", {63'd0, awready}, 64'd1);

    for (int i = 0; i < 5; i++) run_pkt(vecs[i]);
`ifdef NI_PMU_EN
    chk("pmu_stall_cnt", {32'd0, pmu_stall_cnt}, 64'd5);
    chk("pmu_pkt_cnt", {32'd0, pmu_pkt_cnt}, 64'd5);
`else
    chk("pmu_stall_cnt_off", {32'd0, pmu_stall_cnt}, 64'd0);
    chk("pmu_pkt_cnt_off", {32'd0, pmu_pkt_cnt}, 64'd0);
`endif

    // Reset pulse on the second data beat truncates the packet.
    awaddr = 32'h2000_0000; awid = 4'h1; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1;
    awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h1111_1111; wstrb = 4'hF; out_ready = 1'b1;
    step();
    awvalid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pre_wready", {63'd0, wready}, 64'd1);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid_wready", {63'd0, wready}, 64'd0);
    chk("rst_mid_last", {63'd0, out_last}, 64'd0);
    step();
    chk("rst_mid_awready", {63'd0, awready}, 64'd1);
    wvalid = 1'b0;

    run_pkt(vecs[5]);
    run_pkt(vecs[6]);
`ifdef NI_PMU_EN
    chk("pmu_pkt_cnt_b2b", {32'd0, pmu_pkt_cnt}, 64'd2);
    chk("b_pmu_pkt_cnt_b2b", {32'd0, b_pmu_pkt_cnt}, 64'd2);
    chk("pmu_stall_cnt_b2b", {32'd0, pmu_stall_cnt}, 64'd0);
    chk("b_pmu_stall_cnt_b2b", {32'd0, b_pmu_stall_cnt}, 64'd0);
`else
    chk("pmu_pkt_cnt_b2b_off", {32'd0, pmu_pkt_cnt}, 64'd0);
    chk("b_pmu_pkt_cnt_b2b_off", {32'd0, b_pmu_pkt_cnt}, 64'd0);
    chk("b_pmu_stall_cnt_b2b_off", {32'd0, b_pmu_stall_cnt}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
